// File: rtl/alu_arbiter.sv
// alu_arbiter: two valid/ready requesters share one 8-bit ALU through a
// round-robin (or fixed-priority) grant and a single-entry, id-tagged result register.
module alu_arbiter #(
  parameter int CNT_W = 16,
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  input  logic [2:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  input  logic [2:0]       req1_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_id,
  output logic             rsp_zero,
  input  logic             clr_count,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_SLL  = 3'b110;
  localparam logic [2:0] OP_SRL  = 3'b111;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_rsp_valid;
  logic [7:0]       r_rsp_data;
  logic             r_rsp_id;
  logic             r_rsp_zero;
  logic             r_last_gnt;
  logic [CNT_W-1:0] r_op_count;

  logic [1:0] w_req_valid;
  logic [1:0] w_win;
  logic [1:0] w_ready;
  logic       w_slot_free;
  logic       w_prefer1;
  logic       w_accept;
  logic       w_gnt_id;
  logic [7:0] w_a;
  logic [7:0] w_b;
  logic [2:0] w_sel;
  logic [7:0] w_alu_out;

  assign w_req_valid = {req1_valid, req0_valid};
  assign w_slot_free = !r_rsp_valid || rsp_ready;

  // With both pending, round-robin favours whoever was not granted last.
  assign w_prefer1 = RR_EN ? !r_last_gnt : 1'b0;
  assign w_win[0]  = w_req_valid[0] && (!w_req_valid[1] || !w_prefer1);
  assign w_win[1]  = w_req_valid[1] && (!w_req_valid[0] || w_prefer1);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign w_ready[gi] = w_slot_free && w_win[gi];
    end
  endgenerate

  assign req0_ready = w_ready[0];
  assign req1_ready = w_ready[1];
  assign w_accept   = |w_ready;
  assign w_gnt_id   = w_ready[1];

  assign w_a   = w_gnt_id ? req1_a   : req0_a;
  assign w_b   = w_gnt_id ? req1_b   : req0_b;
  assign w_sel = w_gnt_id ? req1_sel : req0_sel;

  always_comb begin
    w_alu_out = 8'h00;
    case (w_sel)
      OP_AND:  w_alu_out = w_a & w_b;
      OP_OR:   w_alu_out = w_a | w_b;
      OP_XOR:  w_alu_out = w_a ^ w_b;
      OP_XNOR: w_alu_out = ~(w_a ^ w_b);
      OP_ADD:  w_alu_out = w_a + w_b;
      OP_SUB:  w_alu_out = w_a - w_b;
      OP_SLL:  w_alu_out = w_a << w_b[2:0];
      OP_SRL:  w_alu_out = w_a >> w_b[2:0];
      default: w_alu_out = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_rsp_id    <= 1'b0;
      r_rsp_zero  <= 1'b0;
      r_last_gnt  <= 1'b1;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_alu_out;
      r_rsp_id    <= w_gnt_id;
      r_rsp_zero  <= (w_alu_out == 8'h00);
      r_last_gnt  <= w_gnt_id;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (clr_count) begin
      r_op_count <= '0;
    end else if (w_accept && (r_op_count != CNT_MAX)) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign rsp_zero  = r_rsp_zero;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: three instances (round-robin, fixed priority,
// 2-bit counter) share one stimulus stream; each scenario task checks its own results.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid, req1_valid, rsp_ready, clr_count;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_sel, req1_sel;

  logic        a_req0_ready, a_req1_ready, a_rsp_valid, a_rsp_id, a_rsp_zero;
  logic [7:0]  a_rsp_data;
  logic [15:0] a_op_count;
  logic        f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id, f_rsp_zero;
  logic [7:0]  f_rsp_data;
  logic [15:0] f_op_count;
  logic        c_req0_ready, c_req1_ready, c_rsp_valid, c_rsp_id, c_rsp_zero;
  logic [7:0]  c_rsp_data;
  logic [1:0]  c_op_count;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.CNT_W(16), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(a_rsp_data), .rsp_id(a_rsp_id),
    .rsp_zero(a_rsp_zero), .clr_count(clr_count), .op_count(a_op_count));

  alu_arbiter #(.CNT_W(16), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(f_rsp_data), .rsp_id(f_rsp_id),
    .rsp_zero(f_rsp_zero), .clr_count(clr_count), .op_count(f_op_count));

  alu_arbiter #(.CNT_W(2), .RR_EN(1'b1)) dut_c2 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(c_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(c_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp_valid(c_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(c_rsp_data), .rsp_id(c_rsp_id),
    .rsp_zero(c_rsp_zero), .clr_count(clr_count), .op_count(c_op_count));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    req0_valid = v; req0_a = a; req0_b = b; req0_sel = s;
  endtask

  task automatic drive1(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    req1_valid = v; req1_a = a; req1_b = b; req1_sel = s;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if (a_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", a_rsp_valid); end
    checks++; if (a_rsp_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", a_rsp_data); end
    checks++; if (a_rsp_id !== 1'b0) begin failures++; $display("FAIL reset_id got=%b exp=0", a_rsp_id); end
    checks++; if (a_rsp_zero !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", a_rsp_zero); end
    checks++; if (a_op_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", a_op_count); end
    checks++; if ({a_req1_ready, a_req0_ready} !== 2'b01) begin failures++; $display("FAIL reset_readys got=%b exp=01", {a_req1_ready, a_req0_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
    $display("reset: released");
  endtask

  task automatic test_add();
    tick();
    drive0(1'b1, 8'h7F, 8'h01, 3'b100);
    #1;
    checks++; if ({a_req1_ready, a_req0_ready} !== 2'b01) begin failures++; $display("FAIL add_ready got=%b exp=01", {a_req1_ready, a_req0_ready}); end
    tick();
    req0_valid = 1'b0;
    exp_cnt++;
    checks++; if (a_rsp_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", a_rsp_valid); end
    checks++; if ({a_rsp_id, a_rsp_zero, a_rsp_data} !== {1'b0, 1'b0, 8'h80}) begin failures++; $display("FAIL add_rsp got id=%b zero=%b data=%h exp id=0 zero=0 data=80", a_rsp_id, a_rsp_zero, a_rsp_data); end
    checks++; if (a_op_count !== 16'(exp_cnt)) begin failures++; $display("FAIL add_count got=%0d exp=%0d", a_op_count, exp_cnt); end
    $display("add: 7F+01 -> data=%h id=%b", a_rsp_data, a_rsp_id);
  endtask

  task automatic test_sub_xor();
    drive0(1'b1, 8'hA5, 8'hA5, 3'b010);
    #1;
    checks++; if (a_req0_ready !== 1'b1) begin failures++; $display("FAIL xor_ready got=%b exp=1", a_req0_ready); end
    tick();
    req0_valid = 1'b0;
    checks++; if ({a_rsp_valid, a_rsp_id, a_rsp_zero, a_rsp_data} !== {1'b1, 1'b0, 1'b1, 8'h00}) begin failures++; $display("FAIL xor_rsp got v=%b id=%b zero=%b data=%h exp v=1 id=0 zero=1 data=00", a_rsp_valid, a_rsp_id, a_rsp_zero, a_rsp_data); end
    $display("xor: A5^A5 -> data=%h zero=%b", a_rsp_data, a_rsp_zero);
    drive1(1'b1, 8'h00, 8'h01, 3'b101);
    #1;
    checks++; if ({a_req1_ready, a_req0_ready} !== 2'b10) begin failures++; $display("FAIL sub_ready got=%b exp=10", {a_req1_ready, a_req0_ready}); end
    tick();
    req1_valid = 1'b0;
    exp_cnt += 2;
    checks++; if ({a_rsp_valid, a_rsp_id, a_rsp_zero, a_rsp_data} !== {1'b1, 1'b1, 1'b0, 8'hFF}) begin failures++; $display("FAIL sub_rsp got v=%b id=%b zero=%b data=%h exp v=1 id=1 zero=0 data=FF", a_rsp_valid, a_rsp_id, a_rsp_zero, a_rsp_data); end
    $display("sub: 00-01 -> data=%h id=%b", a_rsp_data, a_rsp_id);
  endtask

  task automatic test_round_robin();
    logic       exp_id;
    logic [7:0] exp_data;
    drive0(1'b1, 8'h01, 8'h02, 3'b100);
    drive1(1'b1, 8'hF0, 8'h0F, 3'b001);
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_id   = k[0];
      exp_data = exp_id ? 8'hFF : 8'h03;
      checks++; if ({a_rsp_id, a_rsp_data} !== {exp_id, exp_data}) begin failures++; $display("FAIL rr_%0d got id=%b data=%h exp id=%b data=%h", k, a_rsp_id, a_rsp_data, exp_id, exp_data); end
      checks++; if ({f_rsp_id, f_rsp_data} !== {1'b0, 8'h03}) begin failures++; $display("FAIL fp_%0d got id=%b data=%h exp id=0 data=03", k, f_rsp_id, f_rsp_data); end
      $display("rr: cycle %0d rr_id=%b fp_id=%b", k, a_rsp_id, f_rsp_id);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    exp_cnt += 4;
    checks++; if (a_op_count !== 16'(exp_cnt)) begin failures++; $display("FAIL rr_count got=%0d exp=%0d", a_op_count, exp_cnt); end
  endtask

  task automatic test_shift_stall();
    drive0(1'b1, 8'h81, 8'h0B, 3'b110);
    tick();
    checks++; if (a_rsp_data !== 8'h08) begin failures++; $display("FAIL sll got=%h exp=08", a_rsp_data); end
    drive0(1'b1, 8'h81, 8'h0B, 3'b111);
    tick();
    exp_cnt += 2;
    checks++; if ({a_rsp_id, a_rsp_data} !== {1'b0, 8'h10}) begin failures++; $display("FAIL srl got id=%b data=%h exp id=0 data=10", a_rsp_id, a_rsp_data); end
    $display("shift: SLL -> 08, SRL -> %h", a_rsp_data);
    rsp_ready = 1'b0;
    drive0(1'b1, 8'h0F, 8'hF0, 3'b000);
    drive1(1'b1, 8'hFF, 8'h3C, 3'b000);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({a_req1_ready, a_req0_ready} !== 2'b00) begin failures++; $display("FAIL stall_ready_%0d got=%b exp=00", k, {a_req1_ready, a_req0_ready}); end
      tick();
      checks++; if ({a_rsp_valid, a_rsp_id, a_rsp_zero, a_rsp_data} !== {1'b1, 1'b0, 1'b0, 8'h10}) begin failures++; $display("FAIL stall_hold_%0d got v=%b id=%b zero=%b data=%h exp v=1 id=0 zero=0 data=10", k, a_rsp_valid, a_rsp_id, a_rsp_zero, a_rsp_data); end
      checks++; if (a_op_count !== 16'(exp_cnt)) begin failures++; $display("FAIL stall_count_%0d got=%0d exp=%0d", k, a_op_count, exp_cnt); end
      $display("stall: cycle %0d data=%h", k, a_rsp_data);
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if ({a_req1_ready, a_req0_ready} !== 2'b10) begin failures++; $display("FAIL drain_ready got=%b exp=10", {a_req1_ready, a_req0_ready}); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    exp_cnt++;
    checks++; if ({a_rsp_valid, a_rsp_id, a_rsp_data} !== {1'b1, 1'b1, 8'h3C}) begin failures++; $display("FAIL drain_rr got v=%b id=%b data=%h exp v=1 id=1 data=3C", a_rsp_valid, a_rsp_id, a_rsp_data); end
    checks++; if ({f_rsp_id, f_rsp_zero, f_rsp_data} !== {1'b0, 1'b1, 8'h00}) begin failures++; $display("FAIL drain_fp got id=%b zero=%b data=%h exp id=0 zero=1 data=00", f_rsp_id, f_rsp_zero, f_rsp_data); end
    checks++; if (a_op_count !== 16'(exp_cnt)) begin failures++; $display("FAIL drain_count got=%0d exp=%0d", a_op_count, exp_cnt); end
    $display("drain: rr id=%b data=%h", a_rsp_id, a_rsp_data);
  endtask

  task automatic test_count();
    int exp2;
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    checks++; if (c_op_count !== 2'd0) begin failures++; $display("FAIL clr_idle got=%0d exp=0", c_op_count); end
    drive0(1'b1, 8'h01, 8'h01, 3'b100);
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp2 = (k > 3) ? 3 : k;
      checks++; if (c_op_count !== 2'(exp2)) begin failures++; $display("FAIL sat_%0d got=%0d exp=%0d", k, c_op_count, exp2); end
      $display("count: accept %0d op_count=%0d", k, c_op_count);
    end
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    req0_valid = 1'b0;
    checks++; if (c_op_count !== 2'd0) begin failures++; $display("FAIL clr_accept got=%0d exp=0", c_op_count); end
    checks++; if (a_op_count !== 16'd0) begin failures++; $display("FAIL clr_accept16 got=%0d exp=0", a_op_count); end
    checks++; if ({a_rsp_valid, a_rsp_data} !== {1'b1, 8'h02}) begin failures++; $display("FAIL clr_accept_rsp got v=%b data=%h exp v=1 data=02", a_rsp_valid, a_rsp_data); end
  endtask

  task automatic test_reset_stall();
    drive0(1'b1, 8'h12, 8'h34, 3'b010);
    tick();
    req0_valid = 1'b0;
    rsp_ready  = 1'b0;
    checks++; if ({a_rsp_valid, a_rsp_data} !== {1'b1, 8'h26}) begin failures++; $display("FAIL pre_reset got v=%b data=%h exp v=1 data=26", a_rsp_valid, a_rsp_data); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (a_rsp_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%b exp=0", a_rsp_valid); end
    checks++; if (a_op_count !== 16'd0) begin failures++; $display("FAIL async_count got=%0d exp=0", a_op_count); end
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    drive0(1'b1, 8'h0F, 8'hF0, 3'b001);
    drive1(1'b1, 8'h10, 8'h10, 3'b100);
    #1;
    checks++; if ({a_req1_ready, a_req0_ready} !== 2'b01) begin failures++; $display("FAIL post_reset_ready got=%b exp=01", {a_req1_ready, a_req0_ready}); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if ({a_rsp_valid, a_rsp_id, a_rsp_data} !== {1'b1, 1'b0, 8'hFF}) begin failures++; $display("FAIL post_reset_rsp got v=%b id=%b data=%h exp v=1 id=0 data=FF", a_rsp_valid, a_rsp_id, a_rsp_data); end
    $display("reset_stall: first grant id=%b data=%h", a_rsp_id, a_rsp_data);
  endtask

  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1; clr_count = 1'b0;
    req0_a = 8'h00; req0_b = 8'h00; req0_sel = 3'b000;
    req1_a = 8'h00; req1_b = 8'h00; req1_sel = 3'b000;
    test_reset();
    test_add();
    test_sub_xor();
    test_round_robin();
    test_shift_stall();
    test_count();
    test_reset_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
